// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register/word widths, register-file dump states
// and the read-port mux used by the register file.
package cpu_types_pkg;

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned REG_W    = 5;
   localparam int unsigned NUM_REGS = 32;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DUMP = 2'd1,
      DONE = 2'd2
   } regfile_state_t;

   localparam regbits_t LAST_REG = 5'd31;

   // r0 reads zero; an in-flight write to the selected register wins over storage
   function automatic word_t read_port(input regbits_t sel, input logic byp_en,
                                       input regbits_t wsel, input word_t wdat,
                                       input word_t stored);
      word_t res;
      if (sel == 5'd0) begin
         res = 32'h0000_0000;
      end else if (byp_en && (wsel == sel)) begin
         res = wdat;
      end else begin
         res = stored;
      end
      return res;
   endfunction

endpackage

// File: rtl/regfile_if.sv
// Writeback-to-register-file port bundle with the dump handshake.
interface regfile_if
   import cpu_types_pkg::*;
(
   input logic CLK
);
   logic     WEN;
   regbits_t wsel;
   word_t    wdat;
   logic     halt;
   regbits_t rsel1;
   regbits_t rsel2;
   word_t    rdat1;
   word_t    rdat2;
   logic     halted;
   logic     dump_valid;
   logic     dump_ready;
   regbits_t dump_sel;
   word_t    dump_dat;
   logic     dump_done;

   modport wb (
      input  CLK,
      output WEN, wsel, wdat, halt, rsel1, rsel2, dump_ready,
      input  rdat1, rdat2, halted, dump_valid, dump_sel, dump_dat, dump_done
   );

   modport rf (
      input  CLK,
      input  WEN, wsel, wdat, halt, rsel1, rsel2, dump_ready,
      output rdat1, rdat2, halted, dump_valid, dump_sel, dump_dat, dump_done
   );
endinterface

// File: rtl/regfile_dump_fsm.sv
// Freeze/dump sequencer: leaves IDLE on halt, walks idx through the
// registers under a valid/ready handshake, then parks in DONE until reset.
module regfile_dump_fsm
   import cpu_types_pkg::*;
#(
   parameter logic DUMP_ZERO = 1'b0
) (
   input  logic           CLK,
   input  logic           nRST,
   input  logic           halt,
   input  logic           dump_ready,
   output regfile_state_t state,
   output logic [4:0]     idx,
   output logic           dump_valid,
   output logic           dump_done,
   output logic           halted
);

   regfile_state_t state_r;
   regfile_state_t state_nxt_s;
   logic [4:0]     idx_r;
   logic [4:0]     idx_nxt_s;

   // Next-state and next-index; index 31 is terminal, there is no wrap
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      case (state_r)
         IDLE: begin
            if (halt) begin
               state_nxt_s = DUMP;
               idx_nxt_s   = DUMP_ZERO ? 5'd0 : 5'd1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         DUMP: begin
            if (dump_ready) begin
               if (idx_r == LAST_REG) begin
                  state_nxt_s = DONE;
               end else begin
                  idx_nxt_s = idx_r + 5'd1;
               end
            end else begin
               state_nxt_s = DUMP;
            end
         end
         DONE: begin
            state_nxt_s = DONE;
         end
         default: begin
            state_nxt_s = IDLE;
            idx_nxt_s   = 5'd0;
         end
      endcase
   end

   // State and index registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r <= IDLE;
         idx_r   <= 5'd0;
      end else begin
         state_r <= state_nxt_s;
         idx_r   <= idx_nxt_s;
      end
   end

   assign state      = state_r;
   assign idx        = idx_r;
   assign dump_valid = (state_r == DUMP);
   assign dump_done  = (state_r == DONE);
   assign halted     = (state_r != IDLE);

endmodule

// File: rtl/regfile_sink.sv
// 32x32 architectural register file at the writeback port: r0 reads zero,
// two read ports with same-cycle write bypass, freeze and dump on halt.
module regfile_sink
   import cpu_types_pkg::*;
#(
   parameter logic DUMP_ZERO = 1'b0
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        WEN,
   input  logic [4:0]  wsel,
   input  logic [31:0] wdat,
   input  logic        halt,
   input  logic [4:0]  rsel1,
   input  logic [4:0]  rsel2,
   output logic [31:0] rdat1,
   output logic [31:0] rdat2,
   output logic        halted,
   output logic        dump_valid,
   input  logic        dump_ready,
   output logic [4:0]  dump_sel,
   output logic [31:0] dump_dat,
   output logic        dump_done
);

   word_t          regs_r [NUM_REGS];
   regfile_state_t state_s;
   logic [4:0]     idx_s;
   logic           dump_valid_s;
   logic           wr_open_s;
   word_t          rdat1_s;
   word_t          rdat2_s;

   regfile_dump_fsm #(
      .DUMP_ZERO (DUMP_ZERO)
   ) u_dump_fsm (
      .CLK        (CLK),
      .nRST       (nRST),
      .halt       (halt),
      .dump_ready (dump_ready),
      .state      (state_s),
      .idx        (idx_s),
      .dump_valid (dump_valid_s),
      .dump_done  (dump_done),
      .halted     (halted)
   );

   // Writes and bypass only exist while the file is not frozen
   assign wr_open_s = (state_s == IDLE) && WEN;

   // Storage; a write coinciding with halt still lands because state is IDLE
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= 32'h0000_0000;
         end
      end else begin
         if (wr_open_s && (wsel != 5'd0)) begin
            regs_r[wsel] <= wdat;
         end
      end
   end

   // Read ports bypass independently, so both may hit the same write
   always_comb begin
      rdat1_s = read_port(rsel1, wr_open_s, wsel, wdat, regs_r[rsel1]);
      rdat2_s = read_port(rsel2, wr_open_s, wsel, wdat, regs_r[rsel2]);
   end

   assign rdat1      = rdat1_s;
   assign rdat2      = rdat2_s;
   assign dump_valid = dump_valid_s;
   assign dump_sel   = idx_s;
   assign dump_dat   = dump_valid_s ? regs_r[idx_s] : 32'h0000_0000;

endmodule

// File: tb/tb_regfile_sink.sv
// Directed self-checking bench for regfile_sink: reset, bypass, r0,
// write+halt freeze, handshaked dump and reset in the middle of a dump.
module tb_regfile_sink;

   logic        CLK;
   logic        nRST;
   logic        WEN;
   logic [4:0]  wsel;
   logic [31:0] wdat;
   logic        halt;
   logic [4:0]  rsel1;
   logic [4:0]  rsel2;
   logic [31:0] rdat1;
   logic [31:0] rdat2;
   logic        halted;
   logic        dump_valid;
   logic        dump_ready;
   logic [4:0]  dump_sel;
   logic [31:0] dump_dat;
   logic        dump_done;

   int unsigned pass_cnt;
   int unsigned total_cnt;
   logic [31:0] exp_regs [32];

   regfile_sink dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .WEN        (WEN),
      .wsel       (wsel),
      .wdat       (wdat),
      .halt       (halt),
      .rsel1      (rsel1),
      .rsel2      (rsel2),
      .rdat1      (rdat1),
      .rdat2      (rdat2),
      .halted     (halted),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_sel   (dump_sel),
      .dump_dat   (dump_dat),
      .dump_done  (dump_done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " halted"},     {31'd0, halted},     32'd0);
      check({tag, " dump_valid"}, {31'd0, dump_valid}, 32'd0);
      check({tag, " dump_sel"},   {27'd0, dump_sel},   32'd0);
      check({tag, " dump_dat"},   dump_dat,            32'd0);
      check({tag, " dump_done"},  {31'd0, dump_done},  32'd0);
      check({tag, " rdat1"},      rdat1,               32'd0);
      check({tag, " rdat2"},      rdat2,               32'd0);
   endtask

   initial begin
      pass_cnt   = 0;
      total_cnt  = 0;
      nRST       = 1'b0;
      WEN        = 1'b0;
      wsel       = 5'd0;
      wdat       = 32'd0;
      halt       = 1'b0;
      rsel1      = 5'd5;
      rsel2      = 5'd0;
      dump_ready = 1'b0;
      for (int i = 0; i < 32; i++) exp_regs[i] = 32'd0;

      // reset state
      #3;
      check_all_zero("reset");
      #9 nRST = 1'b1;
      tick();

      // bypass on r3, then storage readback
      rsel2 = 5'd3;
      #1;
      check("r3 before write", rdat2, 32'd0);
      WEN = 1'b1; wsel = 5'd3; wdat = 32'hDEAD_BEEF; rsel1 = 5'd3;
      #1;
      check("r3 bypass", rdat1, 32'hDEAD_BEEF);
      tick();
      WEN = 1'b0; wdat = 32'd0;
      #1;
      check("r3 stored", rdat1, 32'hDEAD_BEEF);
      exp_regs[3] = 32'hDEAD_BEEF;

      // r0 write discarded
      WEN = 1'b1; wsel = 5'd0; wdat = 32'hFFFF_FFFF; rsel2 = 5'd0;
      #1;
      check("r0 same cycle", rdat2, 32'd0);
      tick();
      WEN = 1'b0;
      #1;
      check("r0 after", rdat2, 32'd0);

      // both ports bypass the same register
      WEN = 1'b1; wsel = 5'd10; wdat = 32'hA5A5_0010; rsel1 = 5'd10; rsel2 = 5'd10;
      #1;
      check("dual bypass p1", rdat1, 32'hA5A5_0010);
      check("dual bypass p2", rdat2, 32'hA5A5_0010);
      tick();
      WEN = 1'b0; wdat = 32'd0;
      #1;
      check("r10 stored", rdat2, 32'hA5A5_0010);
      exp_regs[10] = 32'hA5A5_0010;

      // write r31 together with halt
      WEN = 1'b1; wsel = 5'd31; wdat = 32'h1234_5678; halt = 1'b1; rsel1 = 5'd31;
      #1;
      check("halted before edge", {31'd0, halted}, 32'd0);
      tick();
      exp_regs[31] = 32'h1234_5678;
      WEN = 1'b1; wsel = 5'd31; wdat = 32'h0000_0000; halt = 1'b0;
      #1;
      check("halted after edge", {31'd0, halted}, 32'd1);
      check("dump_valid after halt", {31'd0, dump_valid}, 32'd1);
      check("frozen no bypass", rdat1, 32'h1234_5678);
      tick();
      WEN = 1'b0;
      #1;
      check("frozen write ignored", rdat1, 32'h1234_5678);
      check("halt drop ignored", {31'd0, halted}, 32'd1);

      // dump with ready toggling: each beat held one cycle, then accepted
      for (int k = 1; k < 32; k++) begin
         check($sformatf("beat%0d sel", k), {27'd0, dump_sel}, k);
         check($sformatf("beat%0d dat", k), dump_dat, exp_regs[k]);
         check($sformatf("beat%0d valid", k), {31'd0, dump_valid}, 32'd1);
         tick();
         check($sformatf("beat%0d held sel", k), {27'd0, dump_sel}, k);
         check($sformatf("beat%0d held dat", k), dump_dat, exp_regs[k]);
         dump_ready = 1'b1;
         tick();
         dump_ready = 1'b0;
      end
      #1;
      check("done after last", {31'd0, dump_done}, 32'd1);
      check("valid after last", {31'd0, dump_valid}, 32'd0);
      tick();
      check("done sticky", {31'd0, dump_done}, 32'd1);

      // reset out of DONE, then a second dump interrupted on beat 10
      nRST = 1'b0;
      #1;
      check_all_zero("reset from done");
      nRST = 1'b1;
      tick();
      WEN = 1'b1; wsel = 5'd5; wdat = 32'h0BAD_F00D; rsel1 = 5'd5; rsel2 = 5'd3;
      tick();
      WEN = 1'b0; halt = 1'b1;
      #1;
      check("r5 after reset", rdat1, 32'h0BAD_F00D);
      check("r3 zeroed", rdat2, 32'd0);
      tick();
      halt = 1'b0; dump_ready = 1'b1;
      for (int k = 1; k < 10; k++) tick();
      #1;
      check("beat10 sel", {27'd0, dump_sel}, 32'd10);
      nRST = 1'b0;
      #1;
      check_all_zero("reset mid-dump");
      #1 nRST = 1'b1;
      dump_ready = 1'b0;
      tick();
      tick();
      check("no restart", {31'd0, dump_valid}, 32'd0);
      check("r5 zeroed", rdat1, 32'd0);

      // normal writes after release
      WEN = 1'b1; wsel = 5'd7; wdat = 32'h00C0_FFEE; rsel1 = 5'd7;
      tick();
      WEN = 1'b0; wdat = 32'd0;
      #1;
      check("r7 after release", rdat1, 32'h00C0_FFEE);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
